// File: rtl/lif_pkg.sv
// Shared definitions for the leaky integrate-and-fire pipeline: default widths and the
// fire-stage state encoding.
package lif_pkg;

  localparam int unsigned LifWidth    = 8;
  localparam int unsigned LifCntWidth = 8;

  typedef enum logic [1:0] {
    LifIdle    = 2'd0,
    LifFire    = 2'd1,
    LifRefract = 2'd2
  } lif_fire_state_t;

endpackage

// File: rtl/lif_evt_reg.sv
// One-entry valid/ready holding register for spike timestamps, with a sticky flag that
// records any event dropped because the entry was still occupied.
module lif_evt_reg #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 overflow_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 overflow_q, overflow_d;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    if (push_i) begin
      // A handshake completing on the push edge frees the slot for the new event.
      if (!valid_q || ready_i) begin
        valid_d = 1'b1;
        data_d  = push_data_i;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/lif_spike_gen.sv
// Threshold-and-fire stage with refractory period and timestamped spike events.
// Define LIF_SPIKE_COUNT_EN to build the saturating spike counter and spike_count port.
module lif_spike_gen
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH          = LifWidth,
  parameter int unsigned REFRACT_CYCLES = 4,
  parameter int unsigned CNT_WIDTH      = LifCntWidth
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     membrane,
  input  logic [WIDTH-1:0]     threshold,
  input  logic                 cnt_clr,
  output logic                 spike,
  output logic                 refractory,
  output logic                 current_gate,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CNT_WIDTH-1:0] evt_time,
  output logic                 evt_overflow
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] spike_count
`endif
);

  localparam logic [1:0] StIdle    = LifIdle;
  localparam logic [1:0] StFire    = LifFire;
  localparam logic [1:0] StRefract = LifRefract;

  localparam int unsigned RcW = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
  localparam logic [RcW-1:0] RcLoad = RcW'((REFRACT_CYCLES == 0) ? 0 : REFRACT_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [RcW-1:0]       rcnt_q, rcnt_d;
  logic [CNT_WIDTH-1:0] tick_q, tick_d;
  logic                 fire_edge;

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    fire_edge = 1'b0;
    case (state_q)
      StIdle: begin
        if (membrane >= threshold) begin
          fire_edge = 1'b1;
          state_d   = StFire;
        end
      end
      StFire: begin
        if (REFRACT_CYCLES == 0) begin
          state_d = StIdle;
        end else begin
          state_d = StRefract;
          rcnt_d  = RcLoad;
        end
      end
      StRefract: begin
        if (rcnt_q == '0) begin
          state_d = StIdle;
        end else begin
          rcnt_d = rcnt_q - RcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tick_d = tick_q + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      rcnt_q  <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      tick_q  <= tick_d;
    end
  end

  assign spike        = (state_q == StFire);
  assign refractory   = (state_q == StRefract);
  assign current_gate = (state_q == StIdle);

  lif_evt_reg #(
    .DataWidth (CNT_WIDTH)
  ) u_evt_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (fire_edge),
    .push_data_i (tick_q),
    .ready_i     (evt_ready),
    .valid_o     (evt_valid),
    .data_o      (evt_time),
    .overflow_o  (evt_overflow)
  );

`ifdef LIF_SPIKE_COUNT_EN
  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = '0;
    end else if ((state_q == StFire) && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign spike_count = count_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_lif_spike_gen.sv
// Bench for lif_spike_gen: directed vector table, corner-case sequences and random stimulus
// checked against a timestamp-based reference model of two differently-configured instances.
module tb_lif_spike_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] membrane = '0;
  logic [7:0] threshold = '0;
  logic       cnt_clr = 1'b0;
  logic       evt_ready = 1'b0;

  logic       a_spike, a_refr, a_gate, a_ev, a_ovf;
  logic [7:0] a_et;
  logic       b_spike, b_refr, b_gate, b_ev, b_ovf;
  logic [3:0] b_et;
`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] a_cnt;
  logic [3:0] b_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lif_spike_gen #(
    .WIDTH          (8),
    .REFRACT_CYCLES (4),
    .CNT_WIDTH      (8)
  ) dut_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .membrane     (membrane),
    .threshold    (threshold),
    .cnt_clr      (cnt_clr),
    .spike        (a_spike),
    .refractory   (a_refr),
    .current_gate (a_gate),
    .evt_valid    (a_ev),
    .evt_ready    (evt_ready),
    .evt_time     (a_et),
    .evt_overflow (a_ovf)
`ifdef LIF_SPIKE_COUNT_EN
    ,
    .spike_count  (a_cnt)
`endif
  );

  lif_spike_gen #(
    .WIDTH          (8),
    .REFRACT_CYCLES (0),
    .CNT_WIDTH      (4)
  ) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .membrane     (membrane),
    .threshold    (threshold),
    .cnt_clr      (cnt_clr),
    .spike        (b_spike),
    .refractory   (b_refr),
    .current_gate (b_gate),
    .evt_valid    (b_ev),
    .evt_ready    (evt_ready),
    .evt_time     (b_et),
    .evt_overflow (b_ovf)
`ifdef LIF_SPIKE_COUNT_EN
    ,
    .spike_count  (b_cnt)
`endif
  );

  // Reference model: each instance is described by the cycle index of its last spike.
  int m_r[2]    = '{4, 0};
  int m_tmod[2] = '{256, 16};
  int m_cyc[2];
  int m_tf[2];
  bit m_ev[2];
  int m_et[2];
  bit m_ovf[2];
  int m_cnt[2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cyc[d] = 0;
      m_tf[d]  = -100;
      m_ev[d]  = 1'b0;
      m_et[d]  = 0;
      m_ovf[d] = 1'b0;
      m_cnt[d] = 0;
    end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      int  c;
      bit  spiking, fire;
      c       = m_cyc[d];
      spiking = (c == m_tf[d]);
      fire    = (c > m_tf[d] + m_r[d]) && (membrane >= threshold);
      if (fire) begin
        if (!m_ev[d] || evt_ready) begin
          m_ev[d] = 1'b1;
          m_et[d] = c % m_tmod[d];
        end else begin
          m_ovf[d] = 1'b1;
        end
        m_tf[d] = c + 1;
      end else if (m_ev[d] && evt_ready) begin
        m_ev[d] = 1'b0;
      end
      if (cnt_clr) m_cnt[d] = 0;
      else if (spiking && m_cnt[d] < m_tmod[d] - 1) m_cnt[d]++;
      m_cyc[d] = c + 1;
    end
  endtask

  task automatic chk_dut(int d, string tag, logic sp, logic rf, logic gt, logic ev,
                         logic [7:0] et, logic ovf, logic [7:0] cnt);
    int c;
    c = m_cyc[d];
    chk({tag, "_spike"}, sp, 32'(c == m_tf[d]));
    chk({tag, "_refractory"}, rf, 32'((c > m_tf[d]) && (c <= m_tf[d] + m_r[d])));
    chk({tag, "_current_gate"}, gt, 32'(c > m_tf[d] + m_r[d]));
    chk({tag, "_evt_valid"}, ev, 32'(m_ev[d]));
    if (m_ev[d]) chk({tag, "_evt_time"}, et, m_et[d]);
    chk({tag, "_evt_overflow"}, ovf, 32'(m_ovf[d]));
`ifdef LIF_SPIKE_COUNT_EN
    chk({tag, "_spike_count"}, cnt, m_cnt[d]);
`else
    if (cnt != 8'd0) chk({tag, "_spike_count_tie"}, cnt, 0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
`ifdef LIF_SPIKE_COUNT_EN
    chk_dut(0, "a", a_spike, a_refr, a_gate, a_ev, a_et, a_ovf, a_cnt);
    chk_dut(1, "b", b_spike, b_refr, b_gate, b_ev, {4'd0, b_et}, b_ovf, {4'd0, b_cnt});
`else
    chk_dut(0, "a", a_spike, a_refr, a_gate, a_ev, a_et, a_ovf, 8'd0);
    chk_dut(1, "b", b_spike, b_refr, b_gate, b_ev, {4'd0, b_et}, b_ovf, 8'd0);
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] mem;
    logic [7:0] thr;
    logic       sp;
    logic       rf;
    logic       gt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n;

    tbl[0] = '{8'd90,  8'd100, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'd95,  8'd100, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'd100, 8'd100, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'd0,   8'd100, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'd0,   8'd100, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'd0,   8'd100, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'd0,   8'd100, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'd0,   8'd100, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{8'd0,   8'd100, 1'b0, 1'b0, 1'b1};

    model_reset();
    reset_n = 1'b0;
    step();
    step();
    chk("reset_gate", a_gate, 1);
    chk("reset_evt_valid", a_ev, 0);
    chk("reset_evt_time", a_et, 0);
    reset_n   = 1'b1;
    evt_ready = 1'b1;

    // Basic fire and refractory on the REFRACT_CYCLES=4 instance.
    for (int i = 0; i < 9; i++) begin
      membrane  = tbl[i].mem;
      threshold = tbl[i].thr;
      step();
      chk("tbl_spike", a_spike, tbl[i].sp);
      chk("tbl_refractory", a_refr, tbl[i].rf);
      chk("tbl_current_gate", a_gate, tbl[i].gt);
    end

    // Zero refractory with threshold 0: spike every other cycle.
    do_reset();
    threshold = 8'd0;
    membrane  = 8'd0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (b_spike) n++;
    end
    chk("zero_refr_spike_count", n, 5);

    // Two fires while the consumer stalls: first event kept, overflow raised.
    do_reset();
    threshold = 8'd100;
    membrane  = 8'd200;
    evt_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("stall_evt_valid", a_ev, 1);
    chk("stall_evt_time", a_et, 0);
    chk("stall_overflow", a_ovf, 1);
    membrane  = 8'd0;
    evt_ready = 1'b1;
    step();
    chk("drain_evt_valid", a_ev, 0);
    chk("drain_overflow_sticky", a_ovf, 1);

    // Handshake completing on the edge of a second fire.
    do_reset();
    evt_ready = 1'b0;
    membrane  = 8'd200;
    step();
    membrane = 8'd0;
    for (int i = 0; i < 5; i++) step();
    membrane  = 8'd200;
    evt_ready = 1'b1;
    step();
    membrane  = 8'd0;
    evt_ready = 1'b0;
    step();
    chk("fire_hs_evt_valid", a_ev, 1);
    chk("fire_hs_evt_time", a_et, 6);
    chk("fire_hs_overflow", a_ovf, 0);

    // Full-scale threshold fires only on full-scale membrane.
    do_reset();
    threshold = 8'hff;
    membrane  = 8'hfe;
    step();
    step();
    chk("fullscale_no_fire", a_spike, 0);
    membrane = 8'hff;
    step();
    chk("fullscale_fire", a_spike, 1);

    // Reset during refractory with membrane still above threshold.
    do_reset();
    threshold = 8'd100;
    membrane  = 8'd200;
    evt_ready = 1'b0;
    step();
    step();
    chk("pre_reset_refractory", a_refr, 1);
    reset_n = 1'b0;
    step();
    chk("mid_reset_refractory", a_refr, 0);
    chk("mid_reset_gate", a_gate, 1);
    chk("mid_reset_evt_valid", a_ev, 0);
    reset_n = 1'b1;
    step();
    chk("post_reset_spike", a_spike, 1);

`ifdef LIF_SPIKE_COUNT_EN
    // Counter saturation, then clear overlapping a spike of the zero-refractory instance.
    do_reset();
    threshold = 8'd0;
    for (int i = 0; i < 45; i++) step();
    chk("sat_count_b", b_cnt, 15);
    chk("count_a", a_cnt, 8);
    cnt_clr = 1'b1;
    step();
    step();
    chk("clr_count_b", b_cnt, 0);
    cnt_clr = 1'b0;
`endif

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0:       threshold = 8'd0;
          1:       threshold = 8'hff;
          default: threshold = 8'($urandom_range(0, 255));
        endcase
      end
      membrane  = ($urandom_range(0, 7) == 0) ? 8'hff : 8'($urandom_range(0, 255));
      evt_ready = ($urandom_range(0, 2) != 0);
      cnt_clr   = ($urandom_range(0, 40) == 0);
      reset_n   = ($urandom_range(0, 300) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
